// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared constants and types for the audio sample path (channels, mixer and
// the PWM output stage).
//   SAMPLE_WIDTH          width of an unsigned channel sample
//   UNDERRUN_COUNT_WIDTH  width of the saturating underrun counter
//   sample_t              one channel sample
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int SAMPLE_WIDTH         = 9;
   localparam int UNDERRUN_COUNT_WIDTH = 8;

   typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Parameterised synchronous FIFO for audio samples. Strict first-in first-out
// order. The head entry is presented combinationally on pop_data. A push made
// while full is still accepted when a pop happens in the same cycle. There is
// no bypass path: a pop on an empty FIFO does nothing, even if a push arrives
// in the same cycle.
//
// Parameters
//   DATA_W      entry width
//   DEPTH_LOG2  log2 of the number of entries
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset (empties the FIFO)
//   push         write request
//   push_data    data to write
//   pop          read request
//   pop_data     head entry (valid when empty is low)
//   full         no free entry
//   empty        no stored entry
//   push_accept  the push is taken this cycle
//   pop_accept   the pop is taken this cycle
// -----------------------------------------------------------------------------
module sample_fifo #(
   parameter int DATA_W     = 9,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic              push_accept,
   output logic              pop_accept
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [DATA_W-1:0]   mem [DEPTH];
   // The extra pointer MSB tells a full FIFO apart from an empty one.
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

   assign pop_accept  = pop && !empty;
   assign push_accept = push && (!full || pop_accept);

   assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_accept)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage carries data only; it needs no reset because the pointers
   // define what is valid.
   always_ff @(posedge clk) begin
      if (push_accept) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
   end

endmodule

// File: rtl/audio_pwm_output.sv
// -----------------------------------------------------------------------------
// audio_pwm_output
// Sink of the channel sample path. Samples written on i_sample_stb are queued
// in a small FIFO and played out one per PWM period (2^SAMPLE_WIDTH clocks) as
// a single-bit stream for the RC-filtered audio pin. o_period_stb lets
// producers pace their writes to the playout rate.
//
// Build option
//   AUDIO_PWM_SIGMA_DELTA_EN  when defined, the PWM comparator is replaced by
//                             a first-order sigma-delta modulator with the
//                             same ones-density per period.
//
// Parameters
//   SAMPLE_WIDTH     sample width W; PWM period is 2^W clocks
//   FIFO_DEPTH_LOG2  FIFO holds 2^FIFO_DEPTH_LOG2 samples
// Ports
//   i_clk             system clock
//   i_rst_n           asynchronous active-low reset
//   i_sample          unsigned sample, duty = i_sample / 2^W
//   i_sample_stb      one-cycle write strobe for i_sample
//   o_ready           FIFO not full
//   o_overflow        one-cycle pulse after a dropped write
//   o_pwm             registered PWM bit
//   o_period_stb      high on the last clock of each PWM period
//   o_underrun_count  saturating count of periods that found the FIFO empty
// -----------------------------------------------------------------------------
module audio_pwm_output #(
   parameter int SAMPLE_WIDTH    = audio_pkg::SAMPLE_WIDTH,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic [SAMPLE_WIDTH-1:0]                   i_sample,
   input  logic                                      i_sample_stb,
   output logic                                      o_ready,
   output logic                                      o_overflow,
   output logic                                      o_pwm,
   output logic                                      o_period_stb,
   output logic [audio_pkg::UNDERRUN_COUNT_WIDTH-1:0] o_underrun_count
);

   import audio_pkg::*;

   localparam logic [SAMPLE_WIDTH-1:0] CNT_LAST = '1;
   localparam logic [SAMPLE_WIDTH-1:0] CNT_ONE  = {{(SAMPLE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [UNDERRUN_COUNT_WIDTH-1:0] UC_ONE =
      {{(UNDERRUN_COUNT_WIDTH-1){1'b0}}, 1'b1};

   logic [SAMPLE_WIDTH-1:0] cnt_p0;
   logic [SAMPLE_WIDTH-1:0] duty_p0;
   logic [SAMPLE_WIDTH-1:0] head;
   logic                    armed;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    push_accept;
   logic                    pop_accept;

   function automatic logic [UNDERRUN_COUNT_WIDTH-1:0] sat_inc(
      input logic [UNDERRUN_COUNT_WIDTH-1:0] v
   );
      if (&v) return v;
      return v + UC_ONE;
   endfunction

   assign o_period_stb = (cnt_p0 == CNT_LAST);
   // Pointers are registers, so full already reflects last cycle's push/pop.
   assign o_ready      = !fifo_full;

   sample_fifo #(
      .DATA_W     (SAMPLE_WIDTH),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .push        (i_sample_stb),
      .push_data   (i_sample),
      .pop         (o_period_stb),
      .pop_data    (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .push_accept (push_accept),
      .pop_accept  (pop_accept)
   );

   // ---- stage p0: period counter, duty load, underrun / overflow tracking ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_p0           <= '0;
         duty_p0          <= '0;
         armed            <= 1'b0;
         o_overflow       <= 1'b0;
         o_underrun_count <= '0;
      end else begin
         cnt_p0     <= cnt_p0 + CNT_ONE;
         o_overflow <= i_sample_stb && !push_accept;
         // The new duty takes effect in the cycle the counter reads 0.
         if (pop_accept) begin
            duty_p0 <= head;
            armed   <= 1'b1;
         end else if (o_period_stb && fifo_empty && armed) begin
            // Duty holds; only count starvation once playout has started.
            o_underrun_count <= sat_inc(o_underrun_count);
         end
      end
   end

   // ---- stage p1: modulator output register ----
`ifdef AUDIO_PWM_SIGMA_DELTA_EN
   // The W+1-bit accumulator is kept as its W-bit residue; the carry of each
   // sum goes straight into o_pwm, so it never needs storing twice.
   logic [SAMPLE_WIDTH-1:0] acc_p1;
   logic [SAMPLE_WIDTH:0]   acc_sum;

   assign acc_sum = {1'b0, acc_p1} + {1'b0, duty_p0};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_p1 <= '0;
         o_pwm  <= 1'b0;
      end else begin
         acc_p1 <= acc_sum[SAMPLE_WIDTH-1:0];
         o_pwm  <= acc_sum[SAMPLE_WIDTH];
      end
   end
`else
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pwm <= 1'b0;
      end else begin
         o_pwm <= (cnt_p0 < duty_p0);
      end
   end
`endif

endmodule

// File: tb/tb_audio_pwm_output.sv
module tb_audio_pwm_output;

   logic       clk;
   logic       i_rst_n;
   logic [8:0] i_sample;
   logic       i_sample_stb;
   logic       o_ready;
   logic       o_overflow;
   logic       o_pwm;
   logic       o_period_stb;
   logic [7:0] o_underrun_count;

   int vectors     = 0;
   int miscompares = 0;

   audio_pwm_output #(
      .SAMPLE_WIDTH    (9),
      .FIFO_DEPTH_LOG2 (2)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (i_rst_n),
      .i_sample         (i_sample),
      .i_sample_stb     (i_sample_stb),
      .o_ready          (o_ready),
      .o_overflow       (o_overflow),
      .o_pwm            (o_pwm),
      .o_period_stb     (o_period_stb),
      .o_underrun_count (o_underrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: outputs are sampled at the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic to_stb(input int budget, output int n);
      n = 0;
      while (o_period_stb !== 1'b1 && n < budget) begin
         step();
         n++;
      end
   endtask

   // Called in a period-strobe cycle; runs one full period and ends in the
   // next period-strobe cycle. Any write strobe set by the caller lasts for
   // the first clock only.
   task automatic measure(output int highs, output int first, output int last,
                          output logic ovf1, output logic rdy1, output logic stb_end);
      highs = 0;
      first = 0;
      last  = 0;
      ovf1  = 1'b0;
      rdy1  = 1'b0;
      for (int i = 1; i <= 512; i++) begin
         step();
         if (i == 1) begin
            ovf1         = o_overflow;
            rdy1         = o_ready;
            i_sample_stb = 1'b0;
         end
         if (o_pwm === 1'b1) begin
            highs++;
            if (first == 0) first = i;
            last = i;
         end
      end
      stb_end = o_period_stb;
   endtask

   int wr_val  [6] = '{128, 0, 511, 256, 77, 88};
   int wr_rdy  [6] = '{1, 1, 1, 0, 0, 0};
   int wr_ovf  [6] = '{0, 0, 0, 0, 1, 1};
   int per_duty[7] = '{128, 0, 511, 256, 300, 300, 300};
   int per_unr [7] = '{0, 0, 0, 0, 0, 1, 2};

   initial begin
      int   highs, first, last, n, ones, stbs;
      logic ovf1, rdy1, stbe;

      i_rst_n      = 1'b0;
      i_sample     = '0;
      i_sample_stb = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_pwm",      o_pwm, 0);
      check("rst_ready",    o_ready, 1);
      check("rst_overflow", o_overflow, 0);
      check("rst_stb",      o_period_stb, 0);
      check("rst_underrun", o_underrun_count, 0);

      // Three idle periods: silent, unarmed, strobe every 512 clocks
      i_rst_n = 1'b1;
      ones = 0;
      stbs = 0;
      for (int k = 1; k <= 1535; k++) begin
         step();
         if (o_pwm === 1'b1) ones++;
         if (o_period_stb === 1'b1) stbs++;
         if (k == 511) check("stb_at_511", o_period_stb, 1);
      end
      check("idle_pwm_ones",    ones, 0);
      check("idle_stb_count",   stbs, 3);
      check("idle_stb_aligned", o_period_stb, 1);
      check("idle_underrun",    o_underrun_count, 0);

      // Six writes on consecutive clocks into a depth-4 FIFO
      step();
      for (int w = 0; w < 6; w++) begin
         i_sample     = 9'(wr_val[w]);
         i_sample_stb = 1'b1;
         step();
         check($sformatf("wr%0d_ready", w + 1),    o_ready,    wr_rdy[w]);
         check($sformatf("wr%0d_overflow", w + 1), o_overflow, wr_ovf[w]);
      end
      i_sample_stb = 1'b0;
      step();
      check("ovf_cleared", o_overflow, 0);
      check("full_ready",  o_ready, 0);
      to_stb(600, n);
      check("steps_to_stb", n, 504);

      // Write into the full FIFO on the strobe cycle, then seven periods of
      // playout: four queued values, the strobe-cycle value, then underruns.
      i_sample     = 9'd300;
      i_sample_stb = 1'b1;
      for (int p = 0; p < 7; p++) begin
         measure(highs, first, last, ovf1, rdy1, stbe);
         if (p == 0) begin
            check("stbwr_overflow", ovf1, 0);
            check("stbwr_ready",    rdy1, 0);
         end
         check($sformatf("p%0d_highs", p + 1), highs, per_duty[p]);
         check($sformatf("p%0d_first", p + 1), first, (per_duty[p] != 0) ? 2 : 0);
         check($sformatf("p%0d_last", p + 1),  last,
               (per_duty[p] != 0) ? per_duty[p] + 1 : 0);
         check($sformatf("p%0d_stb_end", p + 1),  stbe, 1);
         check($sformatf("p%0d_underrun", p + 1), o_underrun_count, per_unr[p]);
      end
      check("drained_ready", o_ready, 1);

      // Reset in the middle of a duty-300 period
      repeat (100) step();
      check("mid_pwm_high", o_pwm, 1);
      i_rst_n = 1'b0;
      #1;
      check("async_rst_pwm",      o_pwm, 0);
      check("async_rst_underrun", o_underrun_count, 0);
      check("async_rst_ready",    o_ready, 1);
      check("async_rst_stb",      o_period_stb, 0);
      @(negedge clk);
      i_rst_n = 1'b1;
      to_stb(600, n);
      check("post_rst_steps_to_stb", n, 511);
      measure(highs, first, last, ovf1, rdy1, stbe);
      check("post_rst_highs",    highs, 0);
      check("post_rst_underrun", o_underrun_count, 0);
      check("post_rst_ready",    o_ready, 1);
      check("post_rst_stb_end",  stbe, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
